instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch stage of the pipelined RISC-V core. Owns the program counter, drives the word address into the instruction memory, captures the returned instruction in the same cycle, and buffers fetched instructions with their PCs in a small queue. The queue feeds the decode stage over a valid/ready handshake. Branch and jump redirects from execute flush the queue and reload the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, queue entries; must be a power of two and at least 2.
- NOP, 32'h0000_0013, value driven on `instr` when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- A  out  32  fetch address to the instruction memory; always equal to the PC register.
- RD  in  32  instruction word returned combinationally by the instruction memory for `A`.
- redirect_valid  in  1  taken branch or jump from execute.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  32  head instruction, or NOP when the queue is empty.
- instr_pc  out  32  PC of the head, or 0 when the queue is empty.
- instr_pc_plus4  out  32  `instr_pc` + 4, modulo 2^32. Equals 4 when the queue is empty.
- misalign_err  out  1  one-cycle pulse after a redirect whose target had bits [1:0] != 0.

## Operation
Reset (reset == 0, asynchronous):
- pc = RESET_PC; count = 0; read and write pointers = 0.
- instr_valid = 0; instr = NOP; instr_pc = 0; misalign_err = 0.

Definitions:
- pop = instr_valid && instr_ready.
- push = !redirect_valid && (count < DEPTH || pop).

Each edge with reset high:
- Redirect has priority:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - count and both pointers <= 0, discarding all entries.
  - No push occurs.
  - misalign_err <= |redirect_pc[1:0].
  - A pop that happens in the same cycle still counts as a transfer. Decode must kill it using its own flush.
- Otherwise:
  - On push: write {pc, RD} at the write pointer, then pc <= pc + 4.
  - count <= count + push - pop.
  - Pointers wrap modulo DEPTH.
  - misalign_err <= 0.
- Full queue without pop: pc holds and `A` is re-presented. The instruction memory is stateless, so the refetch is harmless.
- Full queue with pop: push and pop both occur; count stays at DEPTH.
- Empty queue: pop is impossible because instr_valid = 0.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
- instr_valid = (count != 0), registered-state derived. There is no combinational path from instr_ready or redirect_valid to instr_valid, instr, or instr_pc.
- instr_ready only affects state when instr_valid = 1.

## Timing
- `A` comes from a register. `RD` is sampled at the same edge that advances the PC, so the memory must settle within one cycle.
- Reset release: the first edge with reset high pushes mem[RESET_PC]. instr_valid rises after that edge. Latency is 1 cycle.
- Steady state: with instr_ready held high, one instruction transfers per cycle and PCs are consecutive multiples of 4.
- Redirect sampled at edge E:
  - `A` = target after E.
  - The target is pushed at E+1.
  - instr_valid = 1 after E+1.
  - instr_valid is 0 for exactly the cycle between E and E+1.
- Back-to-back redirects: each edge applies the newest target. Nothing is pushed until a cycle with redirect_valid = 0.
- Stall: instr_ready = 0 for k cycles fills the queue after DEPTH cycles, after which pc freezes. On release, transfers resume the next cycle with no gap or duplicate.
- Reset asserted mid-stream: all state returns to reset values immediately, with no clock required.

## Test plan
- Reset, with mem[0..3] = 11,22,33,44 and instr_ready = 1 → after release, instr = 11,22,33,44 on consecutive cycles with instr_pc = 0,4,8,12 and instr_pc_plus4 = 4,8,12,16.
- instr_ready = 0 for 5 cycles from reset → count saturates at 2 and `A` holds at 8. On release, heads are PC 0, 4, 8 in order with no gaps or duplicates.
- Redirect to 0x40 while the queue holds PCs 8 and 12 → both entries are dropped. The next valid head is mem[16] with instr_pc = 0x40, after exactly one invalid cycle.
- Redirect to 0x42 → `A` = 0x40 and misalign_err = 1 for exactly one cycle. The first head is at PC 0x40.
- RESET_PC = 32'hFFFF_FFF8 with instr_ready = 1 → PCs FFFF_FFF8, FFFF_FFFC, 0, 4. instr_pc_plus4 for FFFF_FFFC is 0.
- reset pulsed low mid-stream with the queue full → instr_valid = 0, instr = NOP, and `A` = RESET_PC, all asynchronously before the next edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, instruction memory addressing and a small
// PC/instruction queue feeding decode over a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   A / RD              instruction memory address (PC) / returned word
//   redirect_valid/_pc  branch or jump redirect from execute
//   instr_valid/_ready  handshake towards decode
//   instr, instr_pc     queue head (NOP / 0 when empty)
//   instr_pc_plus4      instr_pc + 4
//   misalign_err        one-cycle pulse after a misaligned redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] A,
  input  logic [31:0] RD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t        q_mem [DEPTH];
  entry_t        head;
  logic [31:0]   pc_q;
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          mis_q;
  logic          pop;
  logic          push;

  assign instr_valid = (cnt_q != '0);
  assign pop  = instr_valid && instr_ready;
  // a pop frees a slot in the same cycle, so a full queue keeps streaming
  assign push = !redirect_valid && ((cnt_q < FULL) || pop);

  assign A            = pc_q;
  assign misalign_err = mis_q;

  assign head           = q_mem[rp_q];
  assign instr          = instr_valid ? head.ins : NOP;
  assign instr_pc       = instr_valid ? head.pc : 32'd0;
  assign instr_pc_plus4 = instr_pc + 32'd4;

  // storage needs no reset: entries are only visible through count
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wp_q] <= '{pc: pc_q, ins: RD};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q  <= {redirect_pc[31:2], 2'b00};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      mis_q <= |redirect_pc[1:0];
    end else begin
      if (push) begin
        pc_q <= pc_q + 32'd4;
        wp_q <= wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + AW'(1);
      end
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      mis_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// Memory model: word i holds 11*(i+1).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a0, rd0;
  logic        rv = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic        iv, ir;
  logic [31:0] ins, ipc, ip4;
  logic        mis;

  logic [31:0] a1, rd1;
  logic        iv1;
  logic [31:0] ins1, ipc1, ip41;
  logic        mis1;

  int total = 0;
  int bad = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'd11;
  endfunction

  assign rd0 = memf(a0);
  assign rd1 = memf(a1);

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .A(a0), .RD(rd0),
    .redirect_valid(rv), .redirect_pc(rpc),
    .instr_valid(iv), .instr_ready(ir),
    .instr(ins), .instr_pc(ipc), .instr_pc_plus4(ip4),
    .misalign_err(mis)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .A(a1), .RD(rd1),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .instr_valid(iv1), .instr_ready(1'b1),
    .instr(ins1), .instr_pc(ipc1), .instr_pc_plus4(ip41),
    .misalign_err(mis1)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b0;
    rv = 1'b0;
    ir = rdy;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ir = 1'b1;
    #1 reset = 1'b0;
    #1;
    total++;
    if (iv !== 1'b0) begin
      bad++; $display("FAIL rst_valid got %b exp 0", iv);
    end
    total++;
    if (ins !== 32'h13) begin
      bad++; $display("FAIL rst_instr got %h exp 00000013", ins);
    end
    total++;
    if (ipc !== 32'd0 || ip4 !== 32'd4) begin
      bad++; $display("FAIL rst_pc got %h/%h exp 0/4", ipc, ip4);
    end
    total++;
    if (a0 !== 32'd0 || mis !== 1'b0) begin
      bad++; $display("FAIL rst_A got %h/%b exp 0/0", a0, mis);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge1();
      total++;
      if (iv !== 1'b1 || ins !== 32'(11 * (i + 1))) begin
        bad++;
        $display("FAIL stream_instr%0d got %b/%0d exp 1/%0d",
                 i, iv, ins, 11 * (i + 1));
      end
      total++;
      if (ipc !== 32'(4 * i) || ip4 !== 32'(4 * i + 4)) begin
        bad++;
        $display("FAIL stream_pc%0d got %0d/%0d exp %0d/%0d",
                 i, ipc, ip4, 4 * i, 4 * i + 4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) edge1();
    total++;
    if (a0 !== 32'd8 || iv !== 1'b1 || ipc !== 32'd0) begin
      bad++;
      $display("FAIL stall_hold got A=%0d v=%b pc=%0d exp 8/1/0",
               a0, iv, ipc);
    end
    ir = 1'b1;
    for (int i = 1; i < 4; i++) begin
      edge1();
      total++;
      if (iv !== 1'b1 || ipc !== 32'(4 * i)
          || ins !== 32'(11 * (i + 1))) begin
        bad++;
        $display("FAIL stall_rel%0d got v=%b pc=%0d ins=%0d exp 1/%0d/%0d",
                 i, iv, ipc, ins, 4 * i, 11 * (i + 1));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    edge1();
    edge1();
    edge1();
    ir = 1'b0;
    edge1();
    total++;
    if (iv !== 1'b1 || ipc !== 32'd8 || a0 !== 32'd16) begin
      bad++;
      $display("FAIL redir_pre got v=%b pc=%0d A=%0d exp 1/8/16",
               iv, ipc, a0);
    end
    rv = 1'b1;
    rpc = 32'h40;
    edge1();
    total++;
    if (iv !== 1'b0 || a0 !== 32'h40 || mis !== 1'b0) begin
      bad++;
      $display("FAIL redir_gap got v=%b A=%h mis=%b exp 0/40/0",
               iv, a0, mis);
    end
    rv = 1'b0;
    ir = 1'b1;
    edge1();
    total++;
    if (iv !== 1'b1 || ipc !== 32'h40 || ins !== 32'd187) begin
      bad++;
      $display("FAIL redir_head got v=%b pc=%h ins=%0d exp 1/40/187",
               iv, ipc, ins);
    end
  endtask

  task automatic test_misalign();
    rv = 1'b1;
    rpc = 32'h42;
    edge1();
    total++;
    if (a0 !== 32'h40 || mis !== 1'b1 || iv !== 1'b0) begin
      bad++;
      $display("FAIL mis_set got A=%h mis=%b v=%b exp 40/1/0",
               a0, mis, iv);
    end
    rv = 1'b0;
    edge1();
    total++;
    if (mis !== 1'b0) begin
      bad++; $display("FAIL mis_pulse got %b exp 0", mis);
    end
    total++;
    if (iv !== 1'b1 || ipc !== 32'h40 || ins !== 32'd187) begin
      bad++;
      $display("FAIL mis_head got v=%b pc=%h ins=%0d exp 1/40/187",
               iv, ipc, ins);
    end
  endtask

  task automatic test_back_to_back();
    rv = 1'b1;
    rpc = 32'h100;
    edge1();
    total++;
    if (a0 !== 32'h100 || iv !== 1'b0) begin
      bad++; $display("FAIL b2b_1 got A=%h v=%b exp 100/0", a0, iv);
    end
    rpc = 32'h200;
    edge1();
    total++;
    if (a0 !== 32'h200 || iv !== 1'b0) begin
      bad++; $display("FAIL b2b_2 got A=%h v=%b exp 200/0", a0, iv);
    end
    rv = 1'b0;
    edge1();
    total++;
    if (iv !== 1'b1 || ipc !== 32'h200 || ins !== 32'd1419) begin
      bad++;
      $display("FAIL b2b_head got v=%b pc=%h ins=%0d exp 1/200/1419",
               iv, ipc, ins);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [4];
    logic [31:0] p4s [4];
    pcs[0] = 32'hFFFF_FFF8; p4s[0] = 32'hFFFF_FFFC;
    pcs[1] = 32'hFFFF_FFFC; p4s[1] = 32'h0000_0000;
    pcs[2] = 32'h0000_0000; p4s[2] = 32'h0000_0004;
    pcs[3] = 32'h0000_0004; p4s[3] = 32'h0000_0008;
    do_reset(1'b1);
    total++;
    if (a1 !== 32'hFFFF_FFF8 || iv1 !== 1'b0) begin
      bad++; $display("FAIL wrap_rst got A=%h v=%b exp fffffff8/0", a1, iv1);
    end
    for (int i = 0; i < 4; i++) begin
      edge1();
      total++;
      if (iv1 !== 1'b1 || ipc1 !== pcs[i] || ip41 !== p4s[i]
          || ins1 !== memf(pcs[i]) || mis1 !== 1'b0) begin
        bad++;
        $display("FAIL wrap%0d got v=%b pc=%h p4=%h exp 1/%h/%h",
                 i, iv1, ipc1, ip41, pcs[i], p4s[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    edge1();
    edge1();
    edge1();
    total++;
    if (iv !== 1'b1 || a0 !== 32'd8) begin
      bad++; $display("FAIL ar_full got v=%b A=%0d exp 1/8", iv, a0);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (iv !== 1'b0 || ins !== 32'h13 || a0 !== 32'd0 || ipc !== 32'd0) begin
      bad++;
      $display("FAIL ar_async got v=%b ins=%h A=%h pc=%h exp 0/13/0/0",
               iv, ins, a0, ipc);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    ir = 1'b1;
    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
